uart_tx_axis_arbiter: RTL and testbench
=======================================

# uart_tx_axis_arbiter

Packet-atomic round-robin arbiter that shares one UART packet transmitter between several AXI-Stream packet sources, e.g. loopback FIFO, debug-bus responses and status reporters. Sits between the per-source `axis_sync_fifo` instances and the single `uart_packet_tx`. Once a source is granted, it holds the grant for the whole packet, so UART packets never interleave. It also enforces the transmitter's maximum packet length.

## Interface

Parameters:
- `NUM_PORTS`, default 4: number of slave streams. Range 2..16.
- `AXIS_TDATA_WIDTH`, default 8: data width of every stream.
- `MAX_PACKET_LEN`, default 16: maximum number of beats forwarded per grant. Must be ≥1.

Ports:
- `i_clk` input, 1: the single clock.
- `i_rst` input, 1: reset. Asynchronous, active-high.
- `i_s_axis_tvalid` input, `NUM_PORTS`: per-source valid.
- `o_s_axis_tready` output, `NUM_PORTS`: per-source ready.
- `i_s_axis_tdata` input, `NUM_PORTS*AXIS_TDATA_WIDTH`: source `k` occupies bits `[k*W +: W]`.
- `i_s_axis_tlast` input, `NUM_PORTS`: per-source end of packet.
- `i_s_axis_tkeep` input, `NUM_PORTS`: per-source byte keep.
- `o_m_axis_tvalid` output, 1: to `uart_packet_tx`.
- `i_m_axis_tready` input, 1: from `uart_packet_tx`.
- `o_m_axis_tdata` output, `AXIS_TDATA_WIDTH`: forwarded data.
- `o_m_axis_tlast` output, 1: source tlast, or a forced tlast.
- `o_m_axis_tkeep` output, 1: forwarded keep.
- `o_m_axis_tid` output, `max(1,$clog2(NUM_PORTS))`: index of the granted source.
- `o_grant` output, `NUM_PORTS`: one-hot grant. Zero when IDLE.
- `o_overlength` output, 1: one-cycle pulse when a tlast is forced.

## Operation

- **State machine: IDLE, BUSY.**
  - IDLE: all `o_s_axis_tready` are 0 and `o_m_axis_tvalid` is 0.
  - If any `i_s_axis_tvalid` is high, choose the first requester searching from `last_grant+1` upward, with wrap modulo `NUM_PORTS`.
  - On that choice, register `grant`, set `last_grant` = `grant`, clear `beat_cnt`, and go to BUSY.
- **BUSY datapath** (combinational pass-through of the granted port `g`):
  - `o_m_axis_tvalid` = `tvalid[g]`; `o_m_axis_tdata`, `o_m_axis_tkeep` and `o_m_axis_tid` = `g` come from port `g`.
  - `o_s_axis_tready[g]` = `i_m_axis_tready`; all other readies are 0.
- **Beat counter.** `beat_cnt` has width `$clog2(MAX_PACKET_LEN+1)` and increments on every master handshake.
  - `force_last` = (`beat_cnt` == `MAX_PACKET_LEN-1`).
  - `o_m_axis_tlast` = `tlast[g]` | `force_last`.
- **Leaving BUSY.** On a master handshake with `o_m_axis_tlast`=1, go to IDLE.
  - If `force_last` was set and `tlast[g]` was 0, pulse `o_overlength` for 1 cycle.
  - The source's remaining beats are arbitrated later as a new packet.
- **Source stalls.** If `tvalid[g]` drops mid-packet, the grant is held indefinitely. There is no timeout.
- **Input ordering.** tdata, tlast and tkeep of non-granted ports are ignored. Requests arriving while BUSY wait; arbitration happens only in IDLE.

## Timing

- **Reset values** (all asynchronous on `i_rst`):
  - state = IDLE, `grant` = 0, `last_grant` = `NUM_PORTS-1` (so port 0 has first priority), `beat_cnt` = 0.
  - `o_grant` = 0, `o_overlength` = 0, `o_m_axis_tvalid` = 0, `o_s_axis_tready` = 0.
  - `o_m_axis_tdata`, `o_m_axis_tlast`, `o_m_axis_tkeep` and `o_m_axis_tid` = 0.
- **Arbitration latency.** Request seen at edge N means BUSY from edge N+1. The first beat is visible on the master in the cycle after the request is first sampled, so there is 1 bubble.
- **Throughput.** One beat per cycle within a packet. Exactly one idle cycle between packets (the IDLE arbitration cycle).
- **Handshake rules.** The master-side tvalid/tdata are combinational from the granted source. AXIS stability holds as long as the source obeys AXIS, because the grant does not change while BUSY. There is no combinational path from `i_m_axis_tready` to `o_m_axis_tvalid`.
- **Reset mid-packet.** Outputs drop to 0 immediately and the packet is truncated; downstream resync is the transmitter's concern. After release, port 0 has first priority.
- **`MAX_PACKET_LEN`=1.** Every beat is forced last; `o_overlength` pulses on every beat whose source tlast=0.

## Test plan

- **Single source.** Port 2 sends a 3-beat packet `0x41 0x42 0x43` with `i_m_axis_tready`=1.
  - Output appears 1 cycle after tvalid rises, with `o_m_axis_tid`=2, `o_grant`=`0100`, tlast on `0x43`.
  - IDLE follows; `o_overlength` never pulses.
- **Fairness.** All 4 ports hold 2-beat packets continuously from reset.
  - Grant order is 0,1,2,3,0,1…, with exactly one idle cycle between packets and no interleaved beats.
- **Backpressure.** Port 1, 4-beat packet; `i_m_axis_tready` toggles 1,0,0,1,…
  - Data is held stable while stalled; `o_s_axis_tready[1]` mirrors tready; the other readies stay 0.
  - Port 3 requesting meanwhile is granted only after port 1's tlast.
- **Overlength.** `MAX_PACKET_LEN`=16; port 0 sends 20 beats with tlast on beat 20.
  - Beat 16 has `o_m_axis_tlast`=1 and `o_overlength` pulses once.
  - Beats 17–20 follow as a second packet after re-arbitration, ending on the source tlast.
- **Source stall.** Port 0 drops tvalid for 50 cycles after beat 2 while port 1 is requesting.
  - Grant stays on port 0 and `o_m_axis_tvalid`=0 during the gap; the packet then completes, then port 1 is granted.
- **Reset mid-packet.** Assert `i_rst` during beat 3 of a port-2 packet.
  - All outputs are 0 in the same cycle.
  - After release, with ports 0 and 2 requesting, port 0 is granted first.

Source files
------------

// File: rtl/uart_tx_axis_arbiter.sv
// uart_tx_axis_arbiter
// Packet-atomic round-robin arbiter that lets several AXI-Stream packet
// sources share one UART packet transmitter. A granted source keeps the
// grant until its packet ends. A packet that runs past MAX_PACKET_LEN is
// cut by a forced tlast; the source's remaining beats are arbitrated
// again as a new packet.

module uart_tx_axis_arbiter #(
    parameter int NUM_PORTS        = 4,
    parameter int AXIS_TDATA_WIDTH = 8,
    parameter int MAX_PACKET_LEN   = 16,
    localparam int TID_W = ($clog2(NUM_PORTS) > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int CNT_W = $clog2(MAX_PACKET_LEN + 1)
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic [NUM_PORTS-1:0]                   i_s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                   o_s_axis_tready,
    input  logic [NUM_PORTS*AXIS_TDATA_WIDTH-1:0]  i_s_axis_tdata,
    input  logic [NUM_PORTS-1:0]                   i_s_axis_tlast,
    input  logic [NUM_PORTS-1:0]                   i_s_axis_tkeep,
    output logic                                   o_m_axis_tvalid,
    input  logic                                   i_m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]            o_m_axis_tdata,
    output logic                                   o_m_axis_tlast,
    output logic                                   o_m_axis_tkeep,
    output logic [TID_W-1:0]                       o_m_axis_tid,
    output logic [NUM_PORTS-1:0]                   o_grant,
    output logic                                   o_overlength
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [NUM_PORTS-1:0] GRANT_ONE      = {{(NUM_PORTS-1){1'b0}}, 1'b1};
    localparam logic [TID_W-1:0]     LAST_GRANT_RST = TID_W'(NUM_PORTS - 1);
    localparam logic [CNT_W-1:0]     CNT_FORCE      = CNT_W'(MAX_PACKET_LEN - 1);

    // Registered state
    state_t                 r_state;
    logic [NUM_PORTS-1:0]   r_grant;
    logic [TID_W-1:0]       r_tid;
    logic [TID_W-1:0]       r_last_grant;
    logic [CNT_W-1:0]       r_beat_cnt;
    logic                   r_overlength;

    // Next-state values
    state_t                 w_state_next;
    logic [NUM_PORTS-1:0]   w_grant_next;
    logic [TID_W-1:0]       w_tid_next;
    logic [TID_W-1:0]       w_last_grant_next;
    logic [CNT_W-1:0]       w_beat_cnt_next;
    logic                   w_overlength_next;

    // Round-robin search results
    logic                   w_req_found;
    logic [TID_W-1:0]       w_req_pick;
    logic [TID_W-1:0]       w_scan_idx;
    logic                   w_scan_hit;

    // Granted-source view and master-side outputs
    logic [AXIS_TDATA_WIDTH-1:0] w_port_tdata [NUM_PORTS];
    logic                        w_src_tvalid;
    logic [AXIS_TDATA_WIDTH-1:0] w_src_tdata;
    logic                        w_src_tlast;
    logic                        w_src_tkeep;
    logic                        w_force_last;
    logic                        w_m_hs;
    logic                        w_m_tvalid;
    logic [AXIS_TDATA_WIDTH-1:0] w_m_tdata;
    logic                        w_m_tlast;
    logic                        w_m_tkeep;
    logic [TID_W-1:0]            w_m_tid;
    logic [NUM_PORTS-1:0]        w_s_tready;

    // Find the first requester after the last granted port, wrapping around.
    always_comb begin
        w_req_found = 1'b0;
        w_req_pick  = '0;
        w_scan_idx  = '0;
        w_scan_hit  = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            w_scan_idx  = TID_W'((int'(r_last_grant) + i) % NUM_PORTS);
            w_scan_hit  = ~w_req_found & i_s_axis_tvalid[w_scan_idx];
            w_req_pick  = w_scan_hit ? w_scan_idx : w_req_pick;
            w_req_found = w_req_found | w_scan_hit;
        end
    end

    // Select the granted source's sideband signals.
    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_port_tdata[k] = i_s_axis_tdata[k*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
        end
        w_src_tvalid = i_s_axis_tvalid[r_tid];
        w_src_tdata  = w_port_tdata[r_tid];
        w_src_tlast  = i_s_axis_tlast[r_tid];
        w_src_tkeep  = i_s_axis_tkeep[r_tid];
        w_force_last = (r_beat_cnt == CNT_FORCE);
    end

    // FSM next-state logic and the BUSY pass-through datapath.
    always_comb begin
        w_state_next      = r_state;
        w_grant_next      = r_grant;
        w_tid_next        = r_tid;
        w_last_grant_next = r_last_grant;
        w_beat_cnt_next   = r_beat_cnt;
        w_overlength_next = 1'b0;
        w_m_tvalid        = 1'b0;
        w_m_tdata         = '0;
        w_m_tlast         = 1'b0;
        w_m_tkeep         = 1'b0;
        w_m_tid           = '0;
        w_s_tready        = '0;
        w_m_hs            = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_found) begin
                    w_state_next      = ST_BUSY;
                    w_grant_next      = GRANT_ONE << w_req_pick;
                    w_tid_next        = w_req_pick;
                    w_last_grant_next = w_req_pick;
                    w_beat_cnt_next   = '0;
                end else begin
                    w_state_next      = ST_IDLE;
                end
            end
            ST_BUSY: begin
                w_m_tvalid = w_src_tvalid;
                w_m_tdata  = w_src_tdata;
                w_m_tlast  = w_src_tlast | w_force_last;
                w_m_tkeep  = w_src_tkeep;
                w_m_tid    = r_tid;
                w_s_tready = r_grant & {NUM_PORTS{i_m_axis_tready}};
                w_m_hs     = w_src_tvalid & i_m_axis_tready;
                if (w_m_hs && w_m_tlast) begin
                    // Packet (or forced cut) complete: release the grant.
                    w_state_next      = ST_IDLE;
                    w_grant_next      = '0;
                    w_beat_cnt_next   = '0;
                    w_overlength_next = w_force_last & ~w_src_tlast;
                end else if (w_m_hs) begin
                    w_beat_cnt_next   = r_beat_cnt + CNT_W'(1);
                end else begin
                    // Stalled source or sink: hold everything.
                    w_beat_cnt_next   = r_beat_cnt;
                end
            end
            default: begin
                w_state_next    = ST_IDLE;
                w_grant_next    = '0;
                w_beat_cnt_next = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant, priority pointer, beat counter and overlength pulse registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_grant      <= '0;
            r_tid        <= '0;
            r_last_grant <= LAST_GRANT_RST;
            r_beat_cnt   <= '0;
            r_overlength <= 1'b0;
        end else begin
            r_grant      <= w_grant_next;
            r_tid        <= w_tid_next;
            r_last_grant <= w_last_grant_next;
            r_beat_cnt   <= w_beat_cnt_next;
            r_overlength <= w_overlength_next;
        end
    end

    assign o_s_axis_tready = w_s_tready;
    assign o_m_axis_tvalid = w_m_tvalid;
    assign o_m_axis_tdata  = w_m_tdata;
    assign o_m_axis_tlast  = w_m_tlast;
    assign o_m_axis_tkeep  = w_m_tkeep;
    assign o_m_axis_tid    = w_m_tid;
    assign o_grant         = r_grant;
    assign o_overlength    = r_overlength;

endmodule

// File: tb/tb_uart_tx_axis_arbiter.sv
// Directed testbench for uart_tx_axis_arbiter with a per-port source model
// and an expected-beat scoreboard.

module tb_uart_tx_axis_arbiter;

    localparam int NP   = 4;
    localparam int W    = 8;
    localparam int MAXL = 16;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [NP-1:0]     i_s_axis_tvalid;
    logic [NP-1:0]     o_s_axis_tready;
    logic [NP*W-1:0]   i_s_axis_tdata;
    logic [NP-1:0]     i_s_axis_tlast;
    logic [NP-1:0]     i_s_axis_tkeep;
    logic              o_m_axis_tvalid;
    logic              i_m_axis_tready;
    logic [W-1:0]      o_m_axis_tdata;
    logic              o_m_axis_tlast;
    logic              o_m_axis_tkeep;
    logic [1:0]        o_m_axis_tid;
    logic [NP-1:0]     o_grant;
    logic              o_overlength;

    uart_tx_axis_arbiter #(
        .NUM_PORTS(NP), .AXIS_TDATA_WIDTH(W), .MAX_PACKET_LEN(MAXL)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_s_axis_tvalid(i_s_axis_tvalid), .o_s_axis_tready(o_s_axis_tready),
        .i_s_axis_tdata(i_s_axis_tdata), .i_s_axis_tlast(i_s_axis_tlast),
        .i_s_axis_tkeep(i_s_axis_tkeep),
        .o_m_axis_tvalid(o_m_axis_tvalid), .i_m_axis_tready(i_m_axis_tready),
        .o_m_axis_tdata(o_m_axis_tdata), .o_m_axis_tlast(o_m_axis_tlast),
        .o_m_axis_tkeep(o_m_axis_tkeep), .o_m_axis_tid(o_m_axis_tid),
        .o_grant(o_grant), .o_overlength(o_overlength)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [1:0] tid;
        logic [7:0] data;
        logic       last;
        logic       keep;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    // Source model storage
    logic [7:0] src_data [NP][64];
    logic       src_last [NP][64];
    int         src_len  [NP];
    int         src_ptr  [NP];
    logic [NP-1:0] stall;
    logic       m_ready;
    logic       bp_en;
    int         bp_idx;

    // Snapshot taken at each falling edge
    logic       snap_mvalid, snap_ready, snap_hs, snap_tlast, snap_tkeep, snap_ovl;
    logic [NP-1:0] snap_grant, snap_sready;
    logic [7:0] snap_tdata;
    logic [1:0] snap_tid;
    logic       hold_pending;
    logic [7:0] hold_data;
    int         cyc = 0;
    int         ovl_cnt = 0;
    int         first_hs, last_hs;
    int         ovl0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic kp(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic add_pkt(input int p, input int n, input logic [7:0] base);
        for (int b = 0; b < n; b++) begin
            src_data[p][src_len[p]] = base + 8'(b);
            src_last[p][src_len[p]] = (b == n - 1);
            src_len[p]++;
        end
    endtask

    task automatic exp_push(input int tid, input logic [7:0] d, input logic last);
        exp_t e;
        e.tid  = 2'(tid);
        e.data = d;
        e.last = last;
        e.keep = kp(d);
        sb_q.push_back(e);
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < NP; k++) begin
            if (src_ptr[k] < src_len[k] && !stall[k]) begin
                i_s_axis_tvalid[k]      = 1'b1;
                i_s_axis_tdata[k*W +: W] = src_data[k][src_ptr[k]];
                i_s_axis_tlast[k]       = src_last[k][src_ptr[k]];
                i_s_axis_tkeep[k]       = kp(src_data[k][src_ptr[k]]);
            end else begin
                i_s_axis_tvalid[k]      = 1'b0;
                i_s_axis_tdata[k*W +: W] = 8'hEE;
                i_s_axis_tlast[k]       = 1'b1;
                i_s_axis_tkeep[k]       = 1'b1;
            end
        end
        i_m_axis_tready = m_ready;
    endtask

    task automatic clear_sources();
        for (int k = 0; k < NP; k++) begin
            src_len[k] = 0;
            src_ptr[k] = 0;
        end
        stall = '0;
    endtask

    // One clock: sample/check at falling edge, advance sources after rising edge.
    task automatic tick();
        logic [NP-1:0] s_hs;
        exp_t e;
        @(negedge i_clk);
        snap_mvalid = o_m_axis_tvalid;
        snap_ready  = i_m_axis_tready;
        snap_grant  = o_grant;
        snap_sready = o_s_axis_tready;
        snap_tdata  = o_m_axis_tdata;
        snap_tlast  = o_m_axis_tlast;
        snap_tkeep  = o_m_axis_tkeep;
        snap_tid    = o_m_axis_tid;
        snap_ovl    = o_overlength;
        snap_hs     = snap_mvalid & snap_ready;
        s_hs        = i_s_axis_tvalid & o_s_axis_tready;
        if (snap_ovl) ovl_cnt++;
        if (hold_pending) begin
            chk("hold_valid", 32'(snap_mvalid), 32'd1);
            chk("hold_data", 32'(snap_tdata), 32'(hold_data));
        end
        hold_pending = snap_mvalid & ~snap_ready;
        hold_data    = snap_tdata;
        if (snap_hs) begin
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected_beat observed=tid%0d/%0h expected=none", snap_tid, snap_tdata);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_tid", 32'(snap_tid), 32'(e.tid));
                chk("sb_data", 32'(snap_tdata), 32'(e.data));
                chk("sb_last", 32'(snap_tlast), 32'(e.last));
                chk("sb_keep", 32'(snap_tkeep), 32'(e.keep));
                chk("sb_grant", 32'(snap_grant), 32'(4'b0001 << e.tid));
            end
        end
        cyc++;
        @(posedge i_clk);
        #1;
        if (!i_rst) begin
            for (int k = 0; k < NP; k++) begin
                if (s_hs[k]) src_ptr[k]++;
            end
        end
        if (bp_en) begin
            m_ready = (bp_idx % 3 == 0);
            bp_idx++;
        end else begin
            m_ready = 1'b1;
        end
        drive_inputs();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        clear_sources();
        sb_q.delete();
        hold_pending = 1'b0;
        bp_en = 1'b0;
        m_ready = 1'b1;
        drive_inputs();
        tick();
        tick();
        i_rst = 1'b0;
        first_hs = -1;
        last_hs = -1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_drain"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // Reset state
        i_rst = 1'b1;
        clear_sources();
        hold_pending = 1'b0;
        bp_en = 1'b0;
        bp_idx = 0;
        m_ready = 1'b1;
        first_hs = -1;
        last_hs = -1;
        drive_inputs();
        tick();
        chk("rst_mvalid", 32'(snap_mvalid), 32'd0);
        chk("rst_grant", 32'(snap_grant), 32'd0);
        chk("rst_sready", 32'(snap_sready), 32'd0);
        chk("rst_ovl", 32'(snap_ovl), 32'd0);
        chk("rst_mside", 32'({snap_tdata, snap_tlast, snap_tkeep, snap_tid}), 32'd0);
        i_rst = 1'b0;
        tick();
        chk("idle_mvalid", 32'(snap_mvalid), 32'd0);

        // Single source: port 2, 41 42 43
        add_pkt(2, 3, 8'h41);
        exp_push(2, 8'h41, 1'b0);
        exp_push(2, 8'h42, 1'b0);
        exp_push(2, 8'h43, 1'b1);
        ovl0 = ovl_cnt;
        drive_inputs();
        tick();
        chk("t1_bubble_mvalid", 32'(snap_mvalid), 32'd0);
        chk("t1_bubble_grant", 32'(snap_grant), 32'd0);
        tick();
        chk("t1_first_mvalid", 32'(snap_mvalid), 32'd1);
        chk("t1_grant", 32'(snap_grant), 32'h4);
        chk("t1_tid", 32'(snap_tid), 32'd2);
        wait_drain("t1", 10);
        tick();
        chk("t1_idle_grant", 32'(snap_grant), 32'd0);
        chk("t1_idle_mvalid", 32'(snap_mvalid), 32'd0);
        tick();
        chk("t1_ovl", 32'(ovl_cnt - ovl0), 32'd0);

        // Fairness: 4 ports, two 2-beat packets each
        do_reset();
        for (int p = 0; p < NP; p++) begin
            add_pkt(p, 2, 8'(p * 16));
            add_pkt(p, 2, 8'(p * 16 + 8));
        end
        for (int pk = 0; pk < 2; pk++) begin
            for (int p = 0; p < NP; p++) begin
                exp_push(p, 8'(p * 16 + pk * 8), 1'b0);
                exp_push(p, 8'(p * 16 + pk * 8 + 1), 1'b1);
            end
        end
        drive_inputs();
        wait_drain("t2", 60);
        chk("t2_span", 32'(last_hs - first_hs + 1), 32'd23);

        // Backpressure: port 1 (4 beats) with port 3 waiting
        do_reset();
        bp_en = 1'b1;
        bp_idx = 1;
        m_ready = 1'b1;
        add_pkt(1, 4, 8'hA0);
        add_pkt(3, 2, 8'hB0);
        exp_push(1, 8'hA0, 1'b0);
        exp_push(1, 8'hA1, 1'b0);
        exp_push(1, 8'hA2, 1'b0);
        exp_push(1, 8'hA3, 1'b1);
        exp_push(3, 8'hB0, 1'b0);
        exp_push(3, 8'hB1, 1'b1);
        drive_inputs();
        n = 0;
        while (sb_q.size() != 0 && n < 80) begin
            tick();
            n++;
            if (snap_grant == 4'b0010)
                chk("t3_sready", 32'(snap_sready), snap_ready ? 32'h2 : 32'h0);
            if (snap_grant == 4'b1000)
                chk("t3_p3_after_p1", 32'(src_ptr[1]), 32'd4);
        end
        chk("t3_drain", 32'(sb_q.size()), 32'd0);
        bp_en = 1'b0;

        // Overlength: 20 beats from port 0, cut after 16
        do_reset();
        add_pkt(0, 20, 8'h01);
        for (int b = 1; b <= 20; b++) exp_push(0, 8'(b), (b == 16) || (b == 20));
        ovl0 = ovl_cnt;
        drive_inputs();
        wait_drain("t4", 80);
        tick();
        tick();
        chk("t4_ovl_count", 32'(ovl_cnt - ovl0), 32'd1);

        // Source stall: port 0 pauses after beat 2, port 1 waiting
        do_reset();
        add_pkt(0, 4, 8'h50);
        add_pkt(1, 2, 8'h60);
        exp_push(0, 8'h50, 1'b0);
        exp_push(0, 8'h51, 1'b0);
        exp_push(0, 8'h52, 1'b0);
        exp_push(0, 8'h53, 1'b1);
        exp_push(1, 8'h60, 1'b0);
        exp_push(1, 8'h61, 1'b1);
        drive_inputs();
        n = 0;
        while (src_ptr[0] < 2 && n < 20) begin
            tick();
            n++;
        end
        chk("t5_reach", 32'(src_ptr[0]), 32'd2);
        stall[0] = 1'b1;
        drive_inputs();
        for (int c = 0; c < 50; c++) begin
            tick();
            chk("t5_gap_grant", 32'(snap_grant), 32'h1);
            chk("t5_gap_mvalid", 32'(snap_mvalid), 32'd0);
        end
        stall[0] = 1'b0;
        drive_inputs();
        wait_drain("t5", 40);

        // Reset during beat 3 of a port-2 packet
        do_reset();
        add_pkt(2, 5, 8'h70);
        for (int b = 0; b < 5; b++) exp_push(2, 8'(8'h70 + b), (b == 4));
        drive_inputs();
        n = 0;
        while (src_ptr[2] < 2 && n < 20) begin
            tick();
            n++;
        end
        chk("t6_sb_left", 32'(sb_q.size()), 32'd3);
        chk("t6_pre_mvalid", 32'(o_m_axis_tvalid), 32'd1);
        i_rst = 1'b1;
        #1;
        chk("t6_rst_mvalid", 32'(o_m_axis_tvalid), 32'd0);
        chk("t6_rst_sready", 32'(o_s_axis_tready), 32'd0);
        chk("t6_rst_grant", 32'(o_grant), 32'd0);
        chk("t6_rst_mside", 32'({o_m_axis_tdata, o_m_axis_tlast, o_m_axis_tkeep, o_m_axis_tid}), 32'd0);
        chk("t6_rst_ovl", 32'(o_overlength), 32'd0);
        hold_pending = 1'b0;
        clear_sources();
        sb_q.delete();
        drive_inputs();
        tick();
        tick();
        i_rst = 1'b0;
        add_pkt(0, 2, 8'h80);
        add_pkt(2, 2, 8'h90);
        exp_push(0, 8'h80, 1'b0);
        exp_push(0, 8'h81, 1'b1);
        exp_push(2, 8'h90, 1'b0);
        exp_push(2, 8'h91, 1'b1);
        drive_inputs();
        tick();
        tick();
        chk("t6_first_grant", 32'(snap_grant), 32'h1);
        wait_drain("t6", 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
